// File: rtl/udp_tx_arbiter_if.sv
// Shared TX bus for udp_tx_arbiter: per-requester header/payload lanes plus the
// single header/payload path towards the UDP stack. The master modport is the arbiter view.
interface udp_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]    req_hdr_valid;
    logic [NUM_REQ-1:0]    req_hdr_ready;
    logic [NUM_REQ*32-1:0] req_dest_ip;
    logic [NUM_REQ*16-1:0] req_dest_port;
    logic [NUM_REQ*16-1:0] req_source_port;
    logic [NUM_REQ*8-1:0]  req_tdata;
    logic [NUM_REQ-1:0]    req_tvalid;
    logic [NUM_REQ-1:0]    req_tlast;
    logic [NUM_REQ-1:0]    req_tready;

    logic        udp_hdr_valid;
    logic        udp_hdr_ready;
    logic [31:0] udp_ip_dest_ip;
    logic [15:0] udp_dest_port;
    logic [15:0] udp_source_port;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;
    logic        m_tready;

    modport master (
        input  req_hdr_valid, req_dest_ip, req_dest_port, req_source_port,
        input  req_tdata, req_tvalid, req_tlast, udp_hdr_ready, m_tready,
        output req_hdr_ready, req_tready, udp_hdr_valid, udp_ip_dest_ip,
        output udp_dest_port, udp_source_port, m_tdata, m_tvalid, m_tlast, m_tuser
    );

    modport slave (
        output req_hdr_valid, req_dest_ip, req_dest_port, req_source_port,
        output req_tdata, req_tvalid, req_tlast, udp_hdr_ready, m_tready,
        input  req_hdr_ready, req_tready, udp_hdr_valid, udp_ip_dest_ip,
        input  udp_dest_port, udp_source_port, m_tdata, m_tvalid, m_tlast, m_tuser
    );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing the UDP TX path among NUM_REQ requesters, with payload truncation.
// Optional per-requester packet and truncation counters under `UDP_ARB_STATS_EN`.
module udp_tx_arbiter #(
    parameter int unsigned  NUM_REQ       = 4,
    parameter int unsigned  MAX_PKT_BYTES = 1472,
    localparam int unsigned GRANT_W       = $clog2(NUM_REQ)
) (
    input  logic                 udp_sys_clk,
    input  logic                 system_reset,
    udp_tx_arbiter_if.master     bus,
    output logic [GRANT_W-1:0]   grant_idx,
    output logic                 busy
`ifdef UDP_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] pkt_count,
    output logic [15:0]           trunc_count
`endif
);

    typedef enum logic [1:0] {StIdle, StHdr, StPayload, StDrain} state_e;

    state_e             state_q, state_d;
    logic [GRANT_W-1:0] rr_q, grant_q;
    logic [GRANT_W-1:0] pick, cand;
    logic               hit;
    logic [15:0]        cnt_q, cnt_d;
    logic [31:0]        ip_q, sel_ip;
    logic [15:0]        dport_q, sport_q, sel_dport, sel_sport;
    logic [7:0]         g_tdata;
    logic               g_tvalid, g_tlast;
    logic               at_limit;

    // Scan starts just past the last winner so every pending requester is served in turn.
    always_comb begin
        hit  = 1'b0;
        pick = rr_q;
        cand = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = GRANT_W'((32'(rr_q) + i) % NUM_REQ);
            if (!hit && bus.req_hdr_valid[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    always_comb begin
        sel_ip    = '0;
        sel_dport = '0;
        sel_sport = '0;
        g_tdata   = '0;
        g_tvalid  = 1'b0;
        g_tlast   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (GRANT_W'(i) == pick) begin
                sel_ip    = bus.req_dest_ip[32*i +: 32];
                sel_dport = bus.req_dest_port[16*i +: 16];
                sel_sport = bus.req_source_port[16*i +: 16];
            end
            if (GRANT_W'(i) == grant_q) begin
                g_tdata  = bus.req_tdata[8*i +: 8];
                g_tvalid = bus.req_tvalid[i];
                g_tlast  = bus.req_tlast[i];
            end
        end
    end

    assign at_limit = (cnt_q == 16'(MAX_PKT_BYTES - 1));

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        bus.req_hdr_ready = '0;
        bus.req_tready    = '0;
        bus.udp_hdr_valid = 1'b0;
        bus.m_tdata       = '0;
        bus.m_tvalid      = 1'b0;
        bus.m_tlast       = 1'b0;
        bus.m_tuser       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    bus.req_hdr_ready[pick] = 1'b1;
                    state_d                 = StHdr;
                end
            end
            StHdr: begin
                bus.udp_hdr_valid = 1'b1;
                if (bus.udp_hdr_ready) begin
                    cnt_d   = '0;
                    state_d = StPayload;
                end
            end
            StPayload: begin
                bus.m_tdata             = g_tdata;
                bus.m_tvalid            = g_tvalid;
                bus.m_tlast             = g_tvalid & (g_tlast | at_limit);
                bus.m_tuser             = g_tvalid & at_limit & ~g_tlast;
                bus.req_tready[grant_q] = bus.m_tready;
                if (g_tvalid && bus.m_tready) begin
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    if (g_tlast) state_d = StIdle;
                    else if (at_limit) state_d = StDrain;
                end
            end
            StDrain: begin
                // Swallow the oversize tail so the requester can finish its packet.
                bus.req_tready[grant_q] = 1'b1;
                if (g_tvalid && g_tlast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge udp_sys_clk) begin
        if (!system_reset) begin
            state_q <= StIdle;
            rr_q    <= GRANT_W'(NUM_REQ - 1);
            grant_q <= '0;
            cnt_q   <= '0;
            ip_q    <= '0;
            dport_q <= '0;
            sport_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && hit) begin
                grant_q <= pick;
                rr_q    <= pick;
                ip_q    <= sel_ip;
                dport_q <= sel_dport;
                sport_q <= sel_sport;
            end
        end
    end

    assign bus.udp_ip_dest_ip  = ip_q;
    assign bus.udp_dest_port   = dport_q;
    assign bus.udp_source_port = sport_q;
    assign grant_idx           = grant_q;
    assign busy                = (state_q != StIdle);

`ifdef UDP_ARB_STATS_EN
    logic fwd_last;
    assign fwd_last = bus.m_tvalid & bus.m_tready & bus.m_tlast;

    always_ff @(posedge udp_sys_clk) begin
        if (!system_reset) begin
            pkt_count   <= '0;
            trunc_count <= '0;
        end else if (fwd_last) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (GRANT_W'(i) == grant_q) begin
                    pkt_count[16*i +: 16] <= pkt_count[16*i +: 16] + 16'd1;
                end
            end
            if (bus.m_tuser) trunc_count <= trunc_count + 16'd1;
        end
    end
`else
    // Without statistics the arbiter carries no counters.
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: directed sequences, a vector table and a
// randomized multi-requester run checked against a packet-level round-robin model.
module tb_udp_tx_arbiter;
    localparam int NR   = 4;
    localparam int MAXB = 4;

    logic udp_sys_clk = 1'b0;
    logic system_reset = 1'b0;
    always #5 udp_sys_clk = ~udp_sys_clk;

    udp_tx_arbiter_if #(.NUM_REQ(NR)) bus ();
    logic [1:0] grant_idx;
    logic       busy;
`ifdef UDP_ARB_STATS_EN
    logic [NR*16-1:0] pkt_count;
    logic [15:0]      trunc_count;
`endif

    udp_tx_arbiter #(.NUM_REQ(NR), .MAX_PKT_BYTES(MAXB)) dut (
        .udp_sys_clk  (udp_sys_clk),
        .system_reset (system_reset),
        .bus          (bus),
        .grant_idx    (grant_idx),
        .busy         (busy)
`ifdef UDP_ARB_STATS_EN
        ,
        .pkt_count    (pkt_count),
        .trunc_count  (trunc_count)
`endif
    );

    typedef struct {
        logic [31:0] ip;
        logic [15:0] dport;
        logic [15:0] sport;
        int          len;
        logic [7:0]  seed;
    } pkt_t;

    typedef struct {
        int          req;
        logic [31:0] ip;
        logic [15:0] dport;
        logic [15:0] sport;
        int          olen;
        logic [7:0]  seed;
        logic        tuser;
    } exp_t;

    typedef struct {
        int req;
        int len;
        int mode;
        int exp_len;
        bit exp_tuser;
    } vec_t;

    pkt_t        txq[NR][$];
    exp_t        expq[$];
    bit          in_pay[NR];
    int          pos[NR];
    int          model_rr;
    int          served[$];
    logic [7:0]  obs[$];
    logic [63:0] hdr_seen_val;
    bit          hdr_seen;
    int          tready_mode;
    bit          gaps;
    int          cyc;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic pkt_t mkpkt(input int len);
        pkt_t p;
        p.ip    = $urandom;
        p.dport = 16'($urandom);
        p.sport = 16'($urandom);
        p.len   = len;
        p.seed  = 8'($urandom);
        return p;
    endfunction

    function automatic exp_t mkexp(input int req, input pkt_t p);
        exp_t e;
        e.req   = req;
        e.ip    = p.ip;
        e.dport = p.dport;
        e.sport = p.sport;
        e.olen  = (p.len < MAXB) ? p.len : MAXB;
        e.seed  = p.seed;
        e.tuser = (p.len > MAXB);
        return e;
    endfunction

    // Packet-level round robin: every loaded requester stays pending until its queue empties.
    function automatic void plan();
        int left[NR];
        int idx[NR];
        int found;
        for (int i = 0; i < NR; i++) begin
            left[i] = txq[i].size();
            idx[i]  = 0;
        end
        for (int n = 0; n < 1000; n++) begin
            found = -1;
            for (int k = 1; k <= NR; k++) begin
                if (found < 0 && left[(model_rr + k) % NR] > 0) found = (model_rr + k) % NR;
            end
            if (found < 0) break;
            expq.push_back(mkexp(found, txq[found][idx[found]]));
            idx[found]++;
            left[found]--;
            model_rr = found;
        end
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NR; i++) if (txq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        logic [NR-1:0]    hv, tv, tl;
        logic [NR*32-1:0] ip;
        logic [NR*16-1:0] dp, sp;
        logic [NR*8-1:0]  td;
        pkt_t             p;
        hv = '0; tv = '0; tl = '0; ip = '0; dp = '0; sp = '0; td = '0;
        for (int i = 0; i < NR; i++) begin
            if (txq[i].size() > 0) begin
                p               = txq[i][0];
                hv[i]           = !in_pay[i];
                ip[32*i +: 32]  = p.ip;
                dp[16*i +: 16]  = p.dport;
                sp[16*i +: 16]  = p.sport;
                tv[i]           = in_pay[i] && (!gaps || $urandom_range(0, 3) != 0);
                td[8*i +: 8]    = p.seed + 8'(pos[i]);
                tl[i]           = (pos[i] == p.len - 1);
            end
        end
        bus.req_hdr_valid   = hv;
        bus.req_dest_ip     = ip;
        bus.req_dest_port   = dp;
        bus.req_source_port = sp;
        bus.req_tdata       = td;
        bus.req_tvalid      = tv;
        bus.req_tlast       = tl;
        case (tready_mode)
            1:       bus.m_tready = (cyc % 2 == 0);
            2:       bus.m_tready = ($urandom_range(0, 2) != 0);
            default: bus.m_tready = 1'b1;
        endcase
        bus.udp_hdr_ready = (tready_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
    endtask

    task automatic finish_pkt(input logic tuser);
        exp_t e;
        int   bad;
        if (expq.size() == 0) begin
            check("unexpected_pkt", 1, 0);
        end else begin
            e   = expq.pop_front();
            bad = 0;
            check("pkt_req", 64'(grant_idx), 64'(e.req));
            check("pkt_hdr_seen", 64'(hdr_seen), 1);
            check("pkt_hdr", hdr_seen_val, {e.ip, e.dport, e.sport});
            check("pkt_len", 64'(obs.size()), 64'(e.olen));
            check("pkt_tuser", 64'(tuser), 64'(e.tuser));
            for (int j = 0; j < obs.size() && j < e.olen; j++) begin
                if (obs[j] !== e.seed + 8'(j)) bad++;
            end
            check("pkt_bytes", 64'(bad), 0);
        end
        served.push_back(int'(grant_idx));
        obs.delete();
        hdr_seen = 1'b0;
    endtask

    task automatic monitor();
        check("tready_other", 64'(bus.req_tready & ~(4'(1) << grant_idx)), 0);
        if (bus.m_tvalid) check("tready_mirror", 64'(bus.req_tready[grant_idx]), 64'(bus.m_tready));
        if (bus.udp_hdr_valid && bus.udp_hdr_ready) begin
            hdr_seen     = 1'b1;
            hdr_seen_val = {bus.udp_ip_dest_ip, bus.udp_dest_port, bus.udp_source_port};
        end
        if (bus.m_tvalid && bus.m_tready) begin
            obs.push_back(bus.m_tdata);
            if (bus.m_tlast) finish_pkt(bus.m_tuser);
            else check("tuser_midpkt", 64'(bus.m_tuser), 0);
        end
    endtask

    task automatic step();
        logic [NR-1:0] hf, pf;
        @(negedge udp_sys_clk);
        hf = bus.req_hdr_valid & bus.req_hdr_ready;
        pf = bus.req_tvalid & bus.req_tready;
        monitor();
        @(posedge udp_sys_clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (hf[i]) begin
                in_pay[i] = 1'b1;
                pos[i]    = 0;
            end
            if (pf[i] && txq[i].size() > 0) begin
                if (pos[i] == txq[i][0].len - 1) begin
                    void'(txq[i].pop_front());
                    in_pay[i] = 1'b0;
                end else begin
                    pos[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || pending() || busy) && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(n < budget), 1);
        check("residual_bytes", 64'(obs.size()), 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin
            txq[i].delete();
            in_pay[i] = 1'b0;
            pos[i]    = 0;
        end
        expq.delete();
        obs.delete();
        served.delete();
        hdr_seen = 1'b0;
    endtask

    task automatic do_reset();
        system_reset = 1'b0;
        clear_model();
        drive();
        @(posedge udp_sys_clk);
        @(posedge udp_sys_clk);
        #1;
        system_reset = 1'b1;
        model_rr     = NR - 1;
    endtask

    logic [7:0] b[4];
    int         order_exp[5];
    vec_t       vt[7];

    initial begin
        tready_mode = 0;
        gaps        = 1'b0;
        cyc         = 0;
        do_reset();

        check("rst_busy", 64'(busy), 0);
        check("rst_grant", 64'(grant_idx), 0);
        check("rst_hdr_valid", 64'(bus.udp_hdr_valid), 0);
        check("rst_m_tvalid", 64'(bus.m_tvalid), 0);
        check("rst_hdr_fields", {bus.udp_ip_dest_ip, bus.udp_dest_port, bus.udp_source_port}, 0);

        // Directed: requester 2, 192.168.1.127:3000 from port 3001, payload DE AD BE EF.
        b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        bus.req_hdr_valid             = 4'b0100;
        bus.req_dest_ip[95:64]        = 32'hC0A8_017F;
        bus.req_dest_port[47:32]      = 16'd3000;
        bus.req_source_port[47:32]    = 16'd3001;
        bus.udp_hdr_ready             = 1'b0;
        bus.m_tready                  = 1'b1;
        @(negedge udp_sys_clk);
        check("t1_hdr_ready", 64'(bus.req_hdr_ready), 64'h4);
        @(posedge udp_sys_clk);
        #1;
        bus.req_hdr_valid = '0;
        check("t1_udp_hdr_valid", 64'(bus.udp_hdr_valid), 1);
        check("t1_grant", 64'(grant_idx), 2);
        check("t1_hdr", {bus.udp_ip_dest_ip, bus.udp_dest_port, bus.udp_source_port},
              {32'hC0A8_017F, 16'd3000, 16'd3001});
        bus.udp_hdr_ready = 1'b1;
        @(posedge udp_sys_clk);
        #1;
        bus.udp_hdr_ready = 1'b0;
        check("t1_hdr_done", 64'(bus.udp_hdr_valid), 0);
        for (int j = 0; j < 4; j++) begin
            bus.req_tvalid         = 4'b0100;
            bus.req_tdata[23:16]   = b[j];
            bus.req_tlast          = (j == 3) ? 4'b0100 : 4'b0000;
            @(negedge udp_sys_clk);
            check("t1_tvalid", 64'(bus.m_tvalid), 1);
            check("t1_tdata", 64'(bus.m_tdata), 64'(b[j]));
            check("t1_tlast", 64'(bus.m_tlast), 64'(j == 3));
            check("t1_tuser", 64'(bus.m_tuser), 0);
            check("t1_req_tready", 64'(bus.req_tready), 64'h4);
            @(posedge udp_sys_clk);
            #1;
        end
        bus.req_tvalid = '0;
        bus.req_tlast  = '0;
        check("t1_idle", 64'(busy), 0);

        // Fairness: all four pending at once after reset.
        do_reset();
        txq[0].push_back(mkpkt(1));
        txq[0].push_back(mkpkt(1));
        for (int i = 1; i < NR; i++) txq[i].push_back(mkpkt(1));
        plan();
        drive();
        run_until_idle(200, "fair_timeout");
        order_exp = '{0, 1, 2, 3, 0};
        check("fair_count", 64'(served.size()), 5);
        for (int i = 0; i < 5 && i < served.size(); i++) check("fair_order", 64'(served[i]), 64'(order_exp[i]));

        // Vector table: {req, len, tready mode, expected out length, expected tuser}.
        vt[0] = '{0, 1, 0, 1, 1'b0};
        vt[1] = '{1, 3, 1, 3, 1'b0};
        vt[2] = '{2, 4, 0, 4, 1'b0};
        vt[3] = '{3, 5, 0, 4, 1'b1};
        vt[4] = '{1, 6, 0, 4, 1'b1};
        vt[5] = '{2, 7, 2, 4, 1'b1};
        vt[6] = '{0, 4, 1, 4, 1'b0};
        for (int v = 0; v < 7; v++) begin
            pkt_t p;
            exp_t e;
            p = mkpkt(vt[v].len);
            txq[vt[v].req].push_back(p);
            e.req   = vt[v].req;
            e.ip    = p.ip;
            e.dport = p.dport;
            e.sport = p.sport;
            e.olen  = vt[v].exp_len;
            e.seed  = p.seed;
            e.tuser = vt[v].exp_tuser;
            expq.push_back(e);
            tready_mode = vt[v].mode;
            drive();
            run_until_idle(200, "vec_timeout");
            model_rr = vt[v].req;
        end

        // Randomized traffic on all requesters with random backpressure and valid gaps.
        for (int r = 0; r < 2; r++) begin
            tready_mode = 2;
            gaps        = 1'b1;
            served.delete();
            for (int i = 0; i < NR; i++) begin
                int cnt;
                cnt = $urandom_range(2, 5);
                for (int k = 0; k < cnt; k++) txq[i].push_back(mkpkt($urandom_range(1, 7)));
            end
            plan();
            drive();
            run_until_idle(4000, "rand_timeout");
        end
        gaps        = 1'b0;
        tready_mode = 0;

        // Reset in the middle of a payload, then check the pointer restarts at requester 0.
        do_reset();
        txq[1].push_back(mkpkt(6));
        plan();
        drive();
        for (int n = 0; n < 100 && obs.size() < 2; n++) step();
        check("mid_reached", 64'(obs.size() >= 2), 1);
        system_reset = 1'b0;
        clear_model();
        drive();
        @(posedge udp_sys_clk);
        #1;
        check("mid_busy", 64'(busy), 0);
        check("mid_grant", 64'(grant_idx), 0);
        check("mid_outs", 64'({bus.udp_hdr_valid, bus.m_tvalid, bus.m_tlast, bus.m_tuser,
                                 bus.req_hdr_ready, bus.req_tready}), 0);
        check("mid_hdr_fields", {bus.udp_ip_dest_ip, bus.udp_dest_port, bus.udp_source_port}, 0);
        system_reset = 1'b1;
        model_rr     = NR - 1;
        txq[3].push_back(mkpkt(2));
        txq[0].push_back(mkpkt(2));
        plan();
        drive();
        run_until_idle(200, "post_rst_timeout");
        check("post_rst_count", 64'(served.size()), 2);
        if (served.size() == 2) begin
            check("post_rst_first", 64'(served[0]), 0);
            check("post_rst_second", 64'(served[1]), 3);
        end

`ifdef UDP_ARB_STATS_EN
        do_reset();
        txq[1].push_back(mkpkt(2));
        txq[1].push_back(mkpkt(3));
        txq[1].push_back(mkpkt(4));
        txq[3].push_back(mkpkt(6));
        plan();
        drive();
        run_until_idle(300, "stats_timeout");
        check("stats_pkt1", 64'(pkt_count[31:16]), 3);
        check("stats_pkt3", 64'(pkt_count[63:48]), 1);
        check("stats_pkt0", 64'(pkt_count[15:0]), 0);
        check("stats_trunc", 64'(trunc_count), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
